timer_ctrl: RTL and testbench

Sequencing controller for the four-digit mm:ss countdown built from cascaded mod-10/mod-6 BCD down-counters.
- Captures keypad digits and loads them into the counter chain.
- Generates the 1 Hz count-enable pulse.
- Handles start, pause and cancel.
- Raises a timed alarm when the chain reaches 00:00.
- Sits between the front-panel inputs and the counter chain's loadn/enable/data pins.

---
 rtl/timer_pkg.sv | 37 +++
 rtl/timer_prescaler.sv | 46 ++++
 rtl/timer_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_timer_ctrl.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/timer_pkg.sv
// ============================================================================
// Package : timer_pkg
// Purpose : Shared types and constants for the mm:ss countdown controller.
//           Holds the controller state encoding, the BCD digit and mm:ss word
//           types, and the entry clamp helper used at start time.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

package timer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ENTRY = 3'd1,
    ST_LOAD  = 3'd2,
    ST_RUN   = 3'd3,
    ST_PAUSE = 3'd4,
    ST_DONE  = 3'd5
  } state_e;

  typedef logic [3:0]  bcd_t;   // single BCD digit
  typedef logic [15:0] mmss_t;  // {min_tens, min_ones, sec_tens, sec_ones}

  localparam bcd_t SEC_TENS_MAX = 4'd5;

  // The entry is kept exactly as typed; only the value handed to the counter
  // chain is limited so the mod-6 seconds-tens stage never gets 6..9.
  function automatic mmss_t clamp_entry(input mmss_t e);
    mmss_t r;
    r = e;
    if (e[7:4] > SEC_TENS_MAX) r[7:4] = SEC_TENS_MAX;
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/timer_prescaler.sv
// ============================================================================
// Module  : timer_prescaler
// Purpose : Free-running 0..TICK_DIV-1 counter that produces the 1 Hz tick.
//           Counts only while en_i is high, so the count is held across a
//           pause; clr_i restarts it from zero.
// Ports   : clock   - system clock, rising edge
//           clrn    - asynchronous active-low reset
//           clr_i   - synchronous clear to 0 (wins over en_i)
//           en_i    - advance the count this cycle
//           tc_o    - count is at TICK_DIV-1 (combinational)
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module timer_prescaler #(
  parameter int TICK_DIV = 100
) (
  input  logic clock,
  input  logic clrn,
  input  logic clr_i,
  input  logic en_i,
  output logic tc_o
);

  localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  assign tc_o = (cnt_q == LAST);

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i)      cnt_d = '0;
    else if (en_i)  cnt_d = tc_o ? '0 : cnt_q + 1'b1;
  end

  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

endmodule

`default_nettype wire

// File: rtl/timer_ctrl.sv
// ============================================================================
// Module  : timer_ctrl
// Purpose : Sequencing controller for a four-digit mm:ss BCD countdown.
//           Captures keypad digits, loads the counter chain, issues the
//           one-per-second count enable, handles start/pause/cancel and
//           raises a timed alarm at 00:00.
// Ports   : clock, clrn          - clock / async active-low reset
//           key_valid, key_digit - keypad strobe and BCD digit
//           start, stop, clear   - one-cycle front-panel requests
//           door_closed          - door sensor (1 = closed)
//           timer_zero           - counter chain reads 00:00
//           load_n, load_data    - parallel load pulse and value to the chain
//           count_en             - one-cycle enable to the seconds-ones stage
//           running, alarm       - status (RUN / DONE)
// Options : DOOR_INTERLOCK_EN - when defined, start needs the door closed and
//           an open door in RUN forces PAUSE. Undefined: door_closed unused.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module timer_ctrl
  import timer_pkg::*;
#(
  parameter int TICK_DIV     = 100,
  parameter int ALARM_CYCLES = 300
) (
  input  logic        clock,
  input  logic        clrn,
  input  logic        key_valid,
  input  logic [3:0]  key_digit,
  input  logic        start,
  input  logic        stop,
  input  logic        clear,
  input  logic        door_closed,
  input  logic        timer_zero,
  output logic        load_n,
  output logic [15:0] load_data,
  output logic        count_en,
  output logic        running,
  output logic        alarm
);

  localparam int ACW = $clog2(ALARM_CYCLES + 1);
  localparam logic [ACW-1:0] ALARM_LAST = ACW'(ALARM_CYCLES - 1);

  state_e         state_q, state_d;
  mmss_t          entry_q, entry_d;
  mmss_t          load_data_q, load_data_d;
  logic           load_n_q, load_n_d;
  logic           count_en_q, count_en_d;
  logic           running_q, running_d;
  logic           alarm_q, alarm_d;
  logic [ACW-1:0] alarm_cnt_q, alarm_cnt_d;

  logic  pre_clr, pre_en, pre_tc;
  logic  door_ok;
  logic  key_ok;
  logic  start_ok;
  mmss_t clamped;

`ifdef DOOR_INTERLOCK_EN
  assign door_ok = door_closed;
`else
  logic unused_door;
  assign unused_door = door_closed;
  assign door_ok     = 1'b1;
`endif

  assign key_ok   = key_valid && (key_digit <= 4'd9);
  assign start_ok = start && door_ok;
  assign clamped  = clamp_entry(entry_q);

  timer_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clock (clock),
    .clrn  (clrn),
    .clr_i (pre_clr),
    .en_i  (pre_en),
    .tc_o  (pre_tc)
  );

  always_comb begin
    state_d     = state_q;
    entry_d     = entry_q;
    load_data_d = load_data_q;
    load_n_d    = 1'b1;
    alarm_cnt_d = alarm_cnt_q;
    pre_clr     = 1'b0;

    case (state_q)
      ST_IDLE, ST_ENTRY: begin
        // stop doubles as clear here, so a coincident start is dropped
        if (stop || clear) begin
          entry_d     = '0;
          load_n_d    = 1'b0;
          load_data_d = '0;
          state_d     = ST_IDLE;
        end else if (start_ok) begin
          if (clamped != '0) begin
            load_n_d    = 1'b0;
            load_data_d = clamped;
            pre_clr     = 1'b1;
            state_d     = ST_LOAD;
          end
        end else if (key_ok) begin
          entry_d     = {entry_q[11:0], key_digit};
          load_n_d    = 1'b0;
          load_data_d = {entry_q[11:0], key_digit};
          state_d     = ST_ENTRY;
        end
      end

      ST_LOAD: state_d = ST_RUN;

      ST_RUN: begin
        // Reaching 00:00 wins so the chain is never stepped past zero.
        if (timer_zero) begin
          alarm_cnt_d = '0;
          state_d     = ST_DONE;
        end else if (stop || !door_ok) begin
          state_d = ST_PAUSE;
        end
      end

      ST_PAUSE: begin
        if (stop || clear) begin
          entry_d     = '0;
          load_n_d    = 1'b0;
          load_data_d = '0;
          state_d     = ST_IDLE;
        end else if (start_ok) begin
          state_d = ST_RUN;
        end
      end

      ST_DONE: begin
        if (stop || clear || (alarm_cnt_q == ALARM_LAST)) begin
          entry_d = '0;
          state_d = ST_IDLE;
        end else begin
          alarm_cnt_d = alarm_cnt_q + 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    // The prescaler only advances on cycles that stay in RUN, so a pause or
    // the final zero sample freezes it and suppresses the tick.
    pre_en     = (state_q == ST_RUN) && (state_d == ST_RUN);
    count_en_d = pre_en && pre_tc;
    running_d  = (state_d == ST_RUN);
    alarm_d    = (state_d == ST_DONE);
  end

  always_ff @(posedge clock or negedge clrn) begin
    if (!clrn) begin
      state_q     <= ST_IDLE;
      entry_q     <= '0;
      load_data_q <= '0;
      load_n_q    <= 1'b1;
      count_en_q  <= 1'b0;
      running_q   <= 1'b0;
      alarm_q     <= 1'b0;
      alarm_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      entry_q     <= entry_d;
      load_data_q <= load_data_d;
      load_n_q    <= load_n_d;
      count_en_q  <= count_en_d;
      running_q   <= running_d;
      alarm_q     <= alarm_d;
      alarm_cnt_q <= alarm_cnt_d;
    end
  end

  assign load_n    = load_n_q;
  assign load_data = load_data_q;
  assign count_en  = count_en_q;
  assign running   = running_q;
  assign alarm     = alarm_q;

endmodule

`default_nettype wire

// File: tb/tb_timer_ctrl.sv
// ============================================================================
// Module  : tb_timer_ctrl
// Purpose : Directed self-checking bench for timer_ctrl with TICK_DIV=4 and
//           a short alarm. Door interlock cases run when DOOR_INTERLOCK_EN
//           is defined.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_timer_ctrl;

  localparam int TICK_DIV     = 4;
  localparam int ALARM_CYCLES = 5;

  logic        clock = 1'b0;
  logic        clrn  = 1'b0;
  logic        key_valid = 1'b0;
  logic [3:0]  key_digit = 4'd0;
  logic        start = 1'b0;
  logic        stop  = 1'b0;
  logic        clear = 1'b0;
  logic        door_closed = 1'b1;
  logic        timer_zero  = 1'b0;
  logic        load_n;
  logic [15:0] load_data;
  logic        count_en;
  logic        running;
  logic        alarm;

  int n_checks = 0;
  int n_errors = 0;

  timer_ctrl #(
    .TICK_DIV     (TICK_DIV),
    .ALARM_CYCLES (ALARM_CYCLES)
  ) dut (
    .clock       (clock),
    .clrn        (clrn),
    .key_valid   (key_valid),
    .key_digit   (key_digit),
    .start       (start),
    .stop        (stop),
    .clear       (clear),
    .door_closed (door_closed),
    .timer_zero  (timer_zero),
    .load_n      (load_n),
    .load_data   (load_data),
    .count_en    (count_en),
    .running     (running),
    .alarm       (alarm)
  );

  always #5 clock = ~clock;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic key(input logic [3:0] d);
    key_valid = 1'b1;
    key_digit = d;
    tick();
    key_valid = 1'b0;
  endtask

  task automatic press_start();
    start = 1'b1; tick(); start = 1'b0;
  endtask

  task automatic press_stop();
    stop = 1'b1; tick(); stop = 1'b0;
  endtask

  task automatic press_clear();
    clear = 1'b1; tick(); clear = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;

    // ---------------- reset values
    tick(); tick();
    chk("rst_load_n",   32'(load_n),    1);
    chk("rst_data",     32'(load_data), 'h0000);
    chk("rst_count_en", 32'(count_en),  0);
    chk("rst_running",  32'(running),   0);
    chk("rst_alarm",    32'(alarm),     0);
    @(negedge clock);
    clrn = 1'b1;
    tick();

    // ---------------- shift entry: 1,2,3,4,5 -> 2345
    key(4'd1); chk("key1_load_n", 32'(load_n), 0);
    chk("key1_data", 32'(load_data), 'h0001);
    key(4'd2); key(4'd3); key(4'd4);
    key(4'd5); chk("key5_load_n", 32'(load_n), 0);
    chk("key5_data", 32'(load_data), 'h2345);
    tick();    chk("key_pulse_end", 32'(load_n), 1);
    key(4'hA); chk("keyA_no_load", 32'(load_n), 1);
    chk("keyA_data_kept", 32'(load_data), 'h2345);

    // ---------------- clear, then start with zero entry is ignored
    press_clear();
    chk("clr_load_n", 32'(load_n), 0);
    chk("clr_data",   32'(load_data), 'h0000);
    press_start();
    chk("start0_no_load", 32'(load_n), 1);
    tick();
    chk("start0_idle", 32'(running), 0);

    // ---------------- 0,9,9 -> raw 0099, loads clamped 0059
    key(4'd0); key(4'd9); key(4'd9);
    chk("raw_0099", 32'(load_data), 'h0099);
    press_start();
    chk("clamp_load_n", 32'(load_n), 0);
    chk("clamp_data",   32'(load_data), 'h0059);
    tick();
    chk("clamp_running", 32'(running), 1);
    for (int k = 1; k <= 5; k++) begin
      tick();
      chk($sformatf("first_ce_%0d", k), 32'(count_en), (k == 4) ? 1 : 0);
    end
    press_stop();
    chk("p1_running", 32'(running), 0);
    press_stop();
    chk("cancel_load_n", 32'(load_n), 0);
    chk("cancel_data",   32'(load_data), 'h0000);

    // ---------------- 1,3,0 start, run to zero, alarm
    key(4'd1); key(4'd3); key(4'd0);
    press_start();
    chk("r130_load_n", 32'(load_n), 0);
    chk("r130_data",   32'(load_data), 'h0130);
    tick();
    chk("r130_running", 32'(running), 1);
    for (int k = 1; k <= 15; k++) begin
      tick();
      chk($sformatf("ce_k%0d", k), 32'(count_en), (k % 4 == 0) ? 1 : 0);
    end
    // RUN cycle with prescaler at terminal count; zero must suppress the tick
    timer_zero = 1'b1;
    tick();
    chk("zero_no_ce",  32'(count_en), 0);
    chk("zero_alarm",  32'(alarm),    1);
    chk("zero_run_lo", 32'(running),  0);
    n = 1;
    for (int i = 0; i < 100 && alarm; i++) begin
      tick();
      if (alarm) n++;
      if (count_en) chk("done_ce", 32'(count_en), 0);
    end
    chk("alarm_len", 32'(n), ALARM_CYCLES);
    timer_zero = 1'b0;
    press_start();
    chk("post_done_entry0", 32'(load_n), 1);

    // ---------------- pause at prescaler 2, resume, cancel
    key(4'd4);
    press_start();
    chk("p_data", 32'(load_data), 'h0004);
    tick();                       // RUN, prescaler 0
    press_clear();                // ignored in RUN; prescaler 1
    chk("clr_in_run_running", 32'(running), 1);
    chk("clr_in_run_load_n",  32'(load_n),  1);
    tick();                       // prescaler 2
    press_stop();
    chk("pause_running", 32'(running),  0);
    chk("pause_ce",      32'(count_en), 0);
    tick(); tick();
    chk("pause_hold_ce", 32'(count_en), 0);
    press_start();                // RUN, prescaler 2
    chk("resume_running", 32'(running),  1);
    chk("resume_ce0",     32'(count_en), 0);
    tick();                       // prescaler 3
    chk("resume_ce1", 32'(count_en), 0);
    tick();
    chk("resume_ce2", 32'(count_en), 1);
    press_stop();
    press_stop();
    chk("cancel2_load_n", 32'(load_n), 0);
    chk("cancel2_data",   32'(load_data), 'h0000);

    // ---------------- start+stop together in ENTRY acts as clear
    key(4'd7);
    chk("k7_data", 32'(load_data), 'h0007);
    start = 1'b1; stop = 1'b1;
    tick();
    start = 1'b0; stop = 1'b0;
    chk("ss_load_n",  32'(load_n), 0);
    chk("ss_data",    32'(load_data), 'h0000);
    press_start();
    chk("ss_start0", 32'(load_n), 1);
    tick();
    chk("ss_idle", 32'(running), 0);

    // ---------------- stop ends the alarm early
    key(4'd2);
    press_start();
    tick();
    timer_zero = 1'b1;
    tick();
    chk("early_alarm", 32'(alarm), 1);
    press_stop();
    chk("early_alarm_off", 32'(alarm), 0);
    timer_zero = 1'b0;

`ifdef DOOR_INTERLOCK_EN
    // ---------------- door interlock
    door_closed = 1'b0;
    key(4'd5);
    chk("door_key", 32'(load_data), 'h0005);
    press_start();
    chk("door_open_start", 32'(load_n), 1);
    tick();
    chk("door_open_idle", 32'(running), 0);
    door_closed = 1'b1;
    press_start();
    chk("door_load", 32'(load_n), 0);
    tick();                       // RUN prescaler 0
    tick(); tick(); tick();       // prescaler 3
    door_closed = 1'b0;
    tick();
    chk("door_pause", 32'(running),  0);
    chk("door_no_ce", 32'(count_en), 0);
    press_start();
    chk("door_resume_blocked", 32'(running), 0);
    door_closed = 1'b1;
    press_start();
    chk("door_resume", 32'(running), 1);
    tick();
    chk("door_resume_ce", 32'(count_en), 1);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

`default_nettype wire
